// File: rtl/oled_flush_ctrl.sv
// Streams a full framebuffer to an OLED over its parallel bus: a fixed 7-byte
// window/write-RAM command preamble followed by N pixel bytes, two cycles per byte.
module oled_flush_ctrl #(
  parameter int COLS      = 128,
  parameter int ROWS      = 128,
  parameter int BPP_BYTES = 2,
  localparam int N        = COLS * ROWS * BPP_BYTES,
  localparam int FB_AW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_done,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [7:0]       fb_dout,
  output logic             oled_cs,
  output logic             oled_e,
  output logic             oled_rw,
  output logic             oled_dc,
  output logic [7:0]       oled_dout
);

  typedef enum logic [2:0] {
    IDLE,
    CMD_LATCH,
    CMD_SEND,
    PIX_LATCH,
    PIX_SEND,
    DONE
  } state_t;

  localparam logic [FB_AW:0]   N_CNT     = (FB_AW+1)'(N);
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(N - 1);

  state_t         state;
  logic [2:0]     cmd_idx;
  logic [FB_AW:0] count;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'h15;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = 8'(COLS - 1);
      3'd3:    cmd_byte = 8'h75;
      3'd4:    cmd_byte = 8'h00;
      3'd5:    cmd_byte = 8'(ROWS - 1);
      default: cmd_byte = 8'h5C;
    endcase
  endfunction

  // Opcodes (0x15, 0x75, 0x5C) go out with dc low; their arguments with dc high.
  function automatic logic cmd_dc(input logic [2:0] idx);
    cmd_dc = !(idx == 3'd0 || idx == 3'd3 || idx == 3'd6);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_idx   <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fb_addr   <= '0;
      oled_cs   <= 1'b1;
      oled_e    <= 1'b1;
      oled_rw   <= 1'b0;
      oled_dc   <= 1'b0;
      oled_dout <= '0;
    end else begin
      oled_rw <= 1'b0;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && init_done) begin
            state   <= CMD_LATCH;
            busy    <= 1'b1;
            oled_cs <= 1'b0;
            fb_addr <= '0;
            cmd_idx <= '0;
            count   <= '0;
          end
        end
        CMD_LATCH: begin
          oled_e    <= 1'b1;
          oled_dout <= cmd_byte(cmd_idx);
          oled_dc   <= cmd_dc(cmd_idx);
          cmd_idx   <= cmd_idx + 3'd1;
          state     <= CMD_SEND;
        end
        CMD_SEND: begin
          oled_e <= 1'b0;
          state  <= (cmd_idx < 3'd7) ? CMD_LATCH : PIX_LATCH;
        end
        PIX_LATCH: begin
          oled_e    <= 1'b1;
          oled_dc   <= 1'b1;
          oled_dout <= fb_dout;
          // Wrap instead of stepping past the last byte so fb_addr stays below N.
          fb_addr   <= (fb_addr == LAST_ADDR) ? '0 : fb_addr + 1'b1;
          count     <= count + 1'b1;
          state     <= PIX_SEND;
        end
        PIX_SEND: begin
          oled_e <= 1'b0;
          state  <= (count < N_CNT) ? PIX_LATCH : DONE;
        end
        DONE: begin
          oled_cs <= 1'b1;
          oled_e  <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
          fb_addr <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_flush_ctrl.sv
// Directed bench for oled_flush_ctrl on a 4x2, 2-byte-per-pixel panel (16 frame bytes).
module tb_oled_flush_ctrl;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst, init_done, start;
  logic       busy, done;
  logic [3:0] fb_addr;
  logic [7:0] fb_dout;
  logic       oled_cs, oled_e, oled_rw, oled_dc;
  logic [7:0] oled_dout;

  int total = 0;
  int passed = 0;
  int done_pulses = 0;

  logic [7:0] cmd_exp [7] = '{8'h15, 8'h00, 8'h03, 8'h75, 8'h00, 8'h01, 8'h5C};
  logic       dc_exp  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  oled_flush_ctrl #(.COLS(4), .ROWS(2), .BPP_BYTES(2)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .start(start),
    .busy(busy), .done(done), .fb_addr(fb_addr), .fb_dout(fb_dout),
    .oled_cs(oled_cs), .oled_e(oled_e), .oled_rw(oled_rw),
    .oled_dc(oled_dc), .oled_dout(oled_dout)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer: byte at address a holds 0xA0+a.
  always @(posedge clk) fb_dout <= 8'hA0 + {4'h0, fb_addr};

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst = 1'b0; init_done = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (oled_cs !== 1'b1) $display("FAIL reset_cs got %b want 1", oled_cs); else passed++;
    total++; if (oled_e !== 1'b1) $display("FAIL reset_e got %b want 1", oled_e); else passed++;
    total++; if (oled_rw !== 1'b0) $display("FAIL reset_rw got %b want 0", oled_rw); else passed++;
    total++; if (oled_dc !== 1'b0) $display("FAIL reset_dc got %b want 0", oled_dc); else passed++;
    total++; if (oled_dout !== 8'h00) $display("FAIL reset_dout got %h want 00", oled_dout); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (fb_addr !== 4'h0) $display("FAIL reset_fb_addr got %h want 0", fb_addr); else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_init_gating;
    bit ok = 1'b1;
    init_done = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || oled_cs !== 1'b1) ok = 1'b0;
    end
    total++; if (!ok) $display("FAIL init_gating got busy=%b cs=%b want busy=0 cs=1", busy, oled_cs); else passed++;
    init_done = 1'b1;
  endtask

  // One full flush from IDLE; checks every byte at its exact latch edge.
  task automatic run_flush(input bit poke);
    logic [7:0] eb;
    logic       edc;
    logic [3:0] ea;
    int         d0;
    d0 = done_pulses;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL start_busy got %b want 1", busy); else passed++;
    total++; if (oled_cs !== 1'b0) $display("FAIL start_cs got %b want 0", oled_cs); else passed++;
    total++; if (fb_addr !== 4'h0) $display("FAIL start_fb_addr got %h want 0", fb_addr); else passed++;
    for (int i = 0; i < N + 7; i++) begin
      if (i < 7) begin
        eb = cmd_exp[i]; edc = dc_exp[i]; ea = 4'h0;
      end else begin
        eb = 8'hA0 + 8'(i - 7); edc = 1'b1; ea = 4'(i - 6);
      end
      @(posedge clk); #1;
      total++; if (oled_dout !== eb) $display("FAIL byte%0d_dout got %h want %h", i, oled_dout, eb); else passed++;
      total++; if (oled_dc !== edc) $display("FAIL byte%0d_dc got %b want %b", i, oled_dc, edc); else passed++;
      total++; if (oled_e !== 1'b1 || fb_addr !== ea) $display("FAIL byte%0d_latch got e=%b addr=%h want e=1 addr=%h", i, oled_e, fb_addr, ea); else passed++;
      if (poke && i == 9) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      total++; if (oled_e !== 1'b0 || busy !== 1'b1) $display("FAIL byte%0d_send got e=%b busy=%b want e=0 busy=1", i, oled_e, busy); else passed++;
    end
    @(posedge clk); #1;
    total++; if (done !== 1'b1) $display("FAIL done_pulse got %b want 1", done); else passed++;
    total++; if (busy !== 1'b0 || oled_cs !== 1'b1 || oled_e !== 1'b1) $display("FAIL done_ctrl got busy=%b cs=%b e=%b want 0 1 1", busy, oled_cs, oled_e); else passed++;
    total++; if (fb_addr !== 4'h0 || oled_rw !== 1'b0) $display("FAIL done_addr got addr=%h rw=%b want 0 0", fb_addr, oled_rw); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL after_done got done=%b busy=%b want 0 0", done, busy); else passed++;
    total++; if (done_pulses !== d0 + 1) $display("FAIL done_count got %0d want %0d", done_pulses - d0, 1); else passed++;
  endtask

  task automatic test_full_flush;
    run_flush(1'b0);
  endtask

  task automatic test_start_during_busy;
    bit ok = 1'b1;
    run_flush(1'b1);
    repeat (10) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) ok = 1'b0;
    end
    total++; if (!ok) $display("FAIL no_queued_start got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid_flush;
    int d0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    d0 = done_pulses;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || oled_cs !== 1'b1) $display("FAIL abort_ctrl got busy=%b cs=%b want 0 1", busy, oled_cs); else passed++;
    total++; if (fb_addr !== 4'h0 || oled_dout !== 8'h00) $display("FAIL abort_data got addr=%h dout=%h want 0 00", fb_addr, oled_dout); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done_pulses !== d0) $display("FAIL abort_idle got busy=%b pulses=%0d want 0 0", busy, done_pulses - d0); else passed++;
    run_flush(1'b0);
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_pulses;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL b2b_start got busy=%b want 1", busy); else passed++;
    repeat (47) @(posedge clk);
    #1;
    total++; if (done !== 1'b1) $display("FAIL b2b_done1 got %b want 1", done); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b1 || fb_addr !== 4'h0) $display("FAIL b2b_restart got done=%b busy=%b addr=%h want 0 1 0", done, busy, fb_addr); else passed++;
    @(posedge clk); #1;
    total++; if (oled_dout !== 8'h15 || oled_dc !== 1'b0) $display("FAIL b2b_first_byte got %h dc=%b want 15 dc=0", oled_dout, oled_dc); else passed++;
    repeat (46) @(posedge clk);
    #1;
    total++; if (done !== 1'b1) $display("FAIL b2b_done2 got %b want 1", done); else passed++;
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_end got done=%b busy=%b want 0 0", done, busy); else passed++;
    total++; if (done_pulses !== d0 + 2) $display("FAIL b2b_pulses got %0d want 2", done_pulses - d0); else passed++;
  endtask

  initial begin
    test_reset;
    test_init_gating;
    test_full_flush;
    test_start_during_busy;
    test_reset_mid_flush;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
